cache_mem_responder: RTL and testbench

- Memory-side responder for the caches interface: serves dcache read/write beats and icache read beats from an internal word-addressed backing store with programmable access latency.
- Sits below dcache/icache in place of the RAM model so both caches can be exercised against a deterministic, stall-generating memory.
- Arbitrates between the two requesters, dcache first. Holds the winner until its beat completes.

---
 rtl/cache_mem_responder_if.sv | 24 ++
 rtl/cache_mem_responder.sv | 130 +++++++++++++
 tb/tb_cache_mem_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// Cache-to-memory request/response bundle shared by dcache and icache.
// Caches drive requests through master; the responder answers through slave.
interface cache_mem_responder_if;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr,
        input  dwait, dload, iwait, iload
    );

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr,
        output dwait, dload, iwait, iload
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Word-addressed memory responder for dcache/icache with fixed access latency.
// Ports: CLK, nRST (sync, active-low), bus (slave: d/i requests in, wait/load out).
module cache_mem_responder #(
    parameter int DEPTH = 512,
    parameter int LAT   = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    cache_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DBUSY,
        IBUSY
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     mem_q [DEPTH];
    logic            we;

    logic            d_req;
    logic [AW-1:0]   d_idx;
    logic [AW-1:0]   i_idx;
    logic            dwait;
    logic            iwait;
    logic [31:0]     dload;
    logic [31:0]     iload;
    logic            unused_addr;

    assign d_req = bus.dREN | bus.dWEN;
    assign d_idx = bus.daddr[AW+1:2];
    assign i_idx = bus.iaddr[AW+1:2];

    // Address bits outside the word index alias away.
    assign unused_addr = ^{bus.daddr[31:AW+2], bus.daddr[1:0],
                           bus.iaddr[31:AW+2], bus.iaddr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        we      = 1'b0;
        dwait   = d_req;
        iwait   = bus.iREN;
        dload   = '0;
        iload   = '0;
        // While reset is held nothing may complete, whatever state_q says.
        if (nRST) begin
            unique case (state_q)
                IDLE: begin
                    if (d_req) begin
                        wr_d    = bus.dWEN;
                        idx_d   = d_idx;
                        data_d  = bus.dstore;
                        cnt_d   = CNT_INIT;
                        state_d = DBUSY;
                    end else if (bus.iREN) begin
                        idx_d   = i_idx;
                        cnt_d   = CNT_INIT;
                        state_d = IBUSY;
                    end
                end
                DBUSY: begin
                    // A changed or dropped request kills the beat.
                    if (!d_req || bus.dWEN != wr_q || d_idx != idx_q) begin
                        state_d = IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                        if (wr_q) begin
                            we = 1'b1;
                        end else begin
                            dload = mem_q[idx_q];
                        end
                    end
                end
                IBUSY: begin
                    if (!bus.iREN || i_idx != idx_q) begin
                        state_d = IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        iwait   = 1'b0;
                        iload   = mem_q[idx_q];
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            if (we) begin
                mem_q[idx_q] <= data_q;
            end
        end
    end

    assign bus.dwait = dwait;
    assign bus.iwait = iwait;
    assign bus.dload = dload;
    assign bus.iload = iload;
endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized bench for cache_mem_responder against a transaction-level model.
// Ports: drives the master side of cache_mem_responder_if plus CLK/nRST.
module tb_cache_mem_responder;
    localparam int DEPTH = 512;
    localparam int LAT   = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    cache_mem_responder_if bus();

    cache_mem_responder #(
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 11)
          | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
        return a;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_reqs();
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.iREN = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // One dcache beat presented from idle; completes LAT cycles later.
    task automatic d_beat(input bit wr,
                          input logic [31:0] a,
                          input logic [31:0] d);
        bus.dWEN   = wr;
        bus.dREN   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.daddr  = a;
        bus.dstore = d;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge CLK);
            check("d_wait", bus.dwait, (c == LAT) ? 0 : 1);
            check("d_iwait", bus.iwait, 0);
            check("d_iload", bus.iload, 0);
            if (c == LAT && !wr)
                check("d_load", bus.dload, model[widx(a)]);
            step();
        end
        if (wr) model[widx(a)] = d;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    task automatic i_beat(input logic [31:0] a);
        bus.iREN  = 1'b1;
        bus.iaddr = a;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge CLK);
            check("i_wait", bus.iwait, (c == LAT) ? 0 : 1);
            check("i_dwait", bus.dwait, 0);
            if (c == LAT)
                check("i_load", bus.iload, model[widx(a)]);
            step();
        end
        bus.iREN = 1'b0;
    endtask

    // Both requesters at once: dcache wins, icache follows after
    // the dcache beat and one idle arbitration cycle.
    task automatic both_beat(input bit wr,
                             input logic [31:0] da,
                             input logic [31:0] dd,
                             input logic [31:0] ia);
        int i_done;
        i_done     = 2 * LAT + 1;
        bus.dWEN   = wr;
        bus.dREN   = !wr;
        bus.daddr  = da;
        bus.dstore = dd;
        bus.iREN   = 1'b1;
        bus.iaddr  = ia;
        for (int c = 0; c <= i_done; c++) begin
            @(negedge CLK);
            check("b_dwait", bus.dwait, (c < LAT) ? 1 : 0);
            if (c == LAT && !wr)
                check("b_dload", bus.dload, model[widx(da)]);
            check("b_iwait", bus.iwait, (c == i_done) ? 0 : 1);
            if (c <= LAT + 1)
                check("b_iload_ng", bus.iload, 0);
            if (c == i_done)
                check("b_iload", bus.iload, model[widx(ia)]);
            step();
            if (c == LAT) begin
                if (wr) model[widx(da)] = dd;
                bus.dREN = 1'b0;
                bus.dWEN = 1'b0;
            end
        end
        bus.iREN = 1'b0;
    endtask

    // Write withdrawn one cycle after presentation: must not commit.
    task automatic d_withdraw(input logic [31:0] a, input logic [31:0] d);
        bus.dWEN   = 1'b1;
        bus.dREN   = 1'b0;
        bus.daddr  = a;
        bus.dstore = d;
        @(negedge CLK);
        check("wd_wait0", bus.dwait, 1);
        step();
        idle_reqs();
        @(negedge CLK);
        check("wd_wait1", bus.dwait, 0);
        step();
    endtask

    task automatic i_withdraw(input logic [31:0] a);
        bus.iREN  = 1'b1;
        bus.iaddr = a;
        @(negedge CLK);
        check("iwd_wait0", bus.iwait, 1);
        step();
        idle_reqs();
        @(negedge CLK);
        check("iwd_wait1", bus.iwait, 0);
        step();
    endtask

    // Write switched to a read after one cycle: write aborts and
    // the read is granted fresh in the following cycle.
    task automatic d_switch(input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [31:0] a2);
        bus.dWEN   = 1'b1;
        bus.dREN   = 1'b0;
        bus.daddr  = a;
        bus.dstore = d;
        step();
        bus.dWEN  = 1'b0;
        bus.dREN  = 1'b1;
        bus.daddr = a2;
        @(negedge CLK);
        check("sw_wait", bus.dwait, 1);
        step();
        d_beat(0, a2, '0);
    endtask

    initial begin
        int mode;
        idle_reqs();
        bus.daddr  = '0;
        bus.dstore = '0;
        bus.iaddr  = '0;
        clear_model();

        nRST = 1'b0;
        repeat (2) step();
        bus.dWEN = 1'b1;
        bus.iREN = 1'b1;
        @(negedge CLK);
        check("rst_dwait_req", bus.dwait, 1);
        check("rst_iwait_req", bus.iwait, 1);
        check("rst_dload", bus.dload, 0);
        check("rst_iload", bus.iload, 0);
        step();
        idle_reqs();
        @(negedge CLK);
        check("rst_dwait_idle", bus.dwait, 0);
        check("rst_iwait_idle", bus.iwait, 0);
        step();
        nRST = 1'b1;

        d_beat(1, 32'h40, 32'hDEADBEEF);
        d_beat(0, 32'h40, '0);

        d_beat(1, 32'h100, 32'h1234);
        both_beat(0, 32'h10, '0, 32'h100);

        d_beat(1, 32'h80, 32'hA);
        d_beat(1, 32'h84, 32'hB);
        d_beat(0, 32'h80, '0);
        d_beat(0, 32'h84, '0);

        d_withdraw(32'h20, 32'h55);
        d_beat(0, 32'h20, '0);
        check("wd_model", model[8], 0);

        d_beat(1, 32'h800, 32'h77);
        d_beat(0, 32'h000, '0);
        d_beat(0, 32'h003, '0);

        bus.dWEN   = 1'b1;
        bus.dREN   = 1'b0;
        bus.daddr  = 32'h30;
        bus.dstore = 32'h99;
        step();
        nRST = 1'b0;
        @(negedge CLK);
        check("mid_rst_dwait", bus.dwait, 1);
        step();
        nRST = 1'b1;
        clear_model();
        d_beat(0, 32'h30, '0);
        d_beat(1, 32'h30, 32'h99);
        d_beat(0, 32'h30, '0);

        repeat (150) begin
            mode = $urandom_range(0, 4);
            case (mode)
                0: d_beat(1'($urandom_range(0, 1)), rand_addr(), $urandom);
                1: i_beat(rand_addr());
                2: both_beat(1'($urandom_range(0, 1)), rand_addr(),
                             $urandom, rand_addr());
                3: if ($urandom_range(0, 1) == 1)
                       d_withdraw(rand_addr(), $urandom);
                   else
                       i_withdraw(rand_addr());
                default: d_switch(rand_addr(), $urandom, rand_addr());
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(negedge CLK);
                check("gap_dwait", bus.dwait, 0);
                check("gap_iwait", bus.iwait, 0);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
